// File: rtl/jtpopeye_colmix_if.sv
// jtpopeye_colmix_if
// Groups the pixel, palette-load and video-output signals of the colour mixer.
//   master : the producer side (pixel sources, ROM download path, video sink)
//   slave  : the colour mixer itself
// Signals:
//   pxl_cen                   pixel clock enable
//   BAKC, BKPAL               background colour index and palette bank bit
//   OBJC                      object colour, OBJC[1:0]==0 is transparent
//   TXT_PXL, TXTC             text pixel on and text colour index
//   LHBL, LVBL                active-low blanking, aligned with pixel inputs
//   prog_addr/data/we         palette RAM write port
//   red, green, blue          3-3-2 RGB output
//   LHBL_dly, LVBL_dly        blanking aligned with RGB output
//   gfx_en                    layer enables, only with JTPOPEYE_LAYER_MASK_EN
interface jtpopeye_colmix_if;
  logic       pxl_cen;
  logic [3:0] BAKC;
  logic       BKPAL;
  logic [5:0] OBJC;
  logic       TXT_PXL;
  logic [3:0] TXTC;
  logic       LHBL;
  logic       LVBL;
  logic [6:0] prog_addr;
  logic [7:0] prog_data;
  logic       prog_we;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       LHBL_dly;
  logic       LVBL_dly;
`ifdef JTPOPEYE_LAYER_MASK_EN
  logic [2:0] gfx_en;
`endif

  modport master (
`ifdef JTPOPEYE_LAYER_MASK_EN
    output gfx_en,
`endif
    output pxl_cen, BAKC, BKPAL, OBJC, TXT_PXL, TXTC, LHBL, LVBL,
    output prog_addr, prog_data, prog_we,
    input  red, green, blue, LHBL_dly, LVBL_dly
  );

  modport slave (
`ifdef JTPOPEYE_LAYER_MASK_EN
    input  gfx_en,
`endif
    input  pxl_cen, BAKC, BKPAL, OBJC, TXT_PXL, TXTC, LHBL, LVBL,
    input  prog_addr, prog_data, prog_we,
    output red, green, blue, LHBL_dly, LVBL_dly
  );
endinterface

// File: rtl/jtpopeye_colmix.sv
// jtpopeye_colmix
// Colour mixer and palette stage behind the background generator. Picks the
// winning layer (text > object > background), looks it up in a 128x8 palette
// RAM loaded from the ROM download path, applies blanking and drives 3-3-2 RGB.
// Three-stage pipeline advancing on pxl_cen: priority/address, palette read,
// output. Palette writes happen on any clk and are not gated by pxl_cen.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset (palette contents are kept)
//   bus   jtpopeye_colmix_if.slave, pixel/palette/video signals
// Parameters:
//   INVERT       1 = palette byte inverted before RGB split (active-low dumps)
//   BLANK_LEVEL  RGB byte shown during blanking
// Optional build macro:
//   JTPOPEYE_LAYER_MASK_EN  adds bus.gfx_en[2:0] layer enables
//                           (bit0 background, bit1 object, bit2 text)
module jtpopeye_colmix #(
  parameter int         INVERT      = 0,
  parameter logic [7:0] BLANK_LEVEL = 8'h00
) (
  input logic              clk,
  input logic              rst,
  jtpopeye_colmix_if.slave bus
);

  localparam logic [7:0] PAL_MASK = (INVERT != 0) ? 8'hFF : 8'h00;

  logic [2:0] gfx_en;
  logic       txt_on;
  logic       obj_on;
  logic [6:0] addr_nx;

  logic [6:0] addr_s1;
  logic       lhbl_s1;
  logic       lvbl_s1;
  logic [7:0] pal_s2;
  logic       lhbl_s2;
  logic       lvbl_s2;
  logic [7:0] rgb;
  logic       lhbl_out;
  logic       lvbl_out;

  logic [7:0] ram [0:127];

`ifdef JTPOPEYE_LAYER_MASK_EN
  assign gfx_en = bus.gfx_en;
`else
  assign gfx_en = 3'b111;
`endif

  // Layer priority. A fully disabled scene falls back to entry 0.
  always_comb begin
    addr_nx = 7'h00;
    txt_on  = bus.TXT_PXL & gfx_en[2];
    obj_on  = (|bus.OBJC[1:0]) & gfx_en[1];
    if (txt_on)
      addr_nx = {3'b010, bus.TXTC};
    else if (obj_on)
      addr_nx = {1'b1, bus.OBJC};
    else if (gfx_en[0])
      addr_nx = {2'b00, bus.BKPAL, bus.BAKC};
    else
      addr_nx = 7'h00;
  end

  // Palette storage has no reset so its contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we)
      ram[bus.prog_addr] <= bus.prog_data;
  end

  // The read below samples the RAM before this edge's write lands, so a
  // same-clock write/read collision returns the old byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_s1  <= 7'h00;
      lhbl_s1  <= 1'b0;
      lvbl_s1  <= 1'b0;
      pal_s2   <= 8'h00;
      lhbl_s2  <= 1'b0;
      lvbl_s2  <= 1'b0;
      rgb      <= 8'h00;
      lhbl_out <= 1'b0;
      lvbl_out <= 1'b0;
    end else if (bus.pxl_cen) begin
      addr_s1  <= addr_nx;
      lhbl_s1  <= bus.LHBL;
      lvbl_s1  <= bus.LVBL;
      pal_s2   <= ram[addr_s1];
      lhbl_s2  <= lhbl_s1;
      lvbl_s2  <= lvbl_s1;
      rgb      <= (lhbl_s2 && lvbl_s2) ? (pal_s2 ^ PAL_MASK) : BLANK_LEVEL;
      lhbl_out <= lhbl_s2;
      lvbl_out <= lvbl_s2;
    end
  end

  assign bus.red      = rgb[2:0];
  assign bus.green    = rgb[5:3];
  assign bus.blue     = rgb[7:6];
  assign bus.LHBL_dly = lhbl_out;
  assign bus.LVBL_dly = lvbl_out;

endmodule

// File: tb/tb_jtpopeye_colmix.sv
// Bench for jtpopeye_colmix: directed palette/priority/blanking/collision/
// reset cases with literal expectations, then randomized traffic checked
// every clock against a queue-based model of the pixel pipeline.
module tb_jtpopeye_colmix;
  localparam int         INV   = 0;
  localparam logic [7:0] BLANK = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtpopeye_colmix_if bus ();

  jtpopeye_colmix #(.INVERT(INV), .BLANK_LEVEL(BLANK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] addr;
    logic       lh;
    logic       lv;
    logic [7:0] data;
  } ent_t;

  logic [7:0]  pal_m [128];
  ent_t        q [$];
  logic [10:0] exp_out;

  function automatic logic [6:0] ref_addr(input logic txt, input logic [3:0] txtc,
                                          input logic [5:0] objc, input logic bkpal,
                                          input logic [3:0] bakc, input logic [2:0] en);
    if (txt && en[2]) return 7'h20 + 7'(txtc);
    if (objc[1:0] != 2'd0 && en[1]) return 7'h40 + 7'(objc);
    if (en[0]) return 7'(bkpal) * 7'd16 + 7'(bakc);
    return 7'h00;
  endfunction

  function automatic logic [7:0] shown(input logic [7:0] b, input logic lh, input logic lv);
    if (lh && lv) return (INV != 0) ? ~b : b;
    return BLANK;
  endfunction

  function automatic logic [10:0] dut_out();
    return {bus.LHBL_dly, bus.LVBL_dly, bus.blue, bus.green, bus.red};
  endfunction

  // Model: each pixel sampled on a pxl_cen edge gets its palette byte on the
  // next pxl_cen edge (before that edge's write) and is shown on the one after.
  always @(posedge clk) begin : model
    ent_t o;
    ent_t n;
    logic [2:0] en;
    logic [10:0] got;
`ifdef JTPOPEYE_LAYER_MASK_EN
    en = bus.gfx_en;
`else
    en = 3'b111;
`endif
    if (rst) begin
      o.addr = 7'h00; o.lh = 1'b0; o.lv = 1'b0; o.data = 8'h00;
      q.delete();
      q.push_back(o);
      q.push_back(o);
      exp_out = 11'h000;
    end else if (bus.pxl_cen) begin
      o = q.pop_front();
      exp_out = {o.lh, o.lv, shown(o.data, o.lh, o.lv)};
      q[0].data = pal_m[q[0].addr];
      n.addr = ref_addr(bus.TXT_PXL, bus.TXTC, bus.OBJC, bus.BKPAL, bus.BAKC, en);
      n.lh = bus.LHBL;
      n.lv = bus.LVBL;
      n.data = 8'h00;
      q.push_back(n);
    end
    if (bus.prog_we) pal_m[bus.prog_addr] = bus.prog_data;
    #1;
    got = dut_out();
    checks++;
    if (got !== exp_out) begin
      errors++;
      $display("FAIL model_cycle t=%0t: got %h expected %h", $time, got, exp_out);
    end
  end

  task automatic chk(input string nm, input logic [10:0] exp);
    logic [10:0] got;
    got = dut_out();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic set_pix(input logic [3:0] bakc, input logic bkpal, input logic [5:0] objc,
                         input logic txt, input logic [3:0] txtc);
    bus.BAKC = bakc; bus.BKPAL = bkpal; bus.OBJC = objc;
    bus.TXT_PXL = txt; bus.TXTC = txtc;
  endtask

  // Hold a pixel for three pxl_cen edges, then check the literal result.
  task automatic pix3(input string nm, input logic [3:0] bakc, input logic bkpal,
                      input logic [5:0] objc, input logic txt, input logic [3:0] txtc,
                      input logic [10:0] exp);
    set_pix(bakc, bkpal, objc, txt, txtc);
    bus.pxl_cen = 1'b1;
    repeat (3) @(negedge clk);
    chk(nm, exp);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    bus.prog_addr = a; bus.prog_data = d; bus.prog_we = 1'b1;
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  initial begin
    bus.pxl_cen = 1'b0;
    set_pix(4'd0, 1'b0, 6'd0, 1'b0, 4'd0);
    bus.LHBL = 1'b1; bus.LVBL = 1'b1;
    bus.prog_addr = 7'd0; bus.prog_data = 8'd0; bus.prog_we = 1'b0;
`ifdef JTPOPEYE_LAYER_MASK_EN
    bus.gfx_en = 3'b111;
`endif
    @(negedge clk);
    for (int i = 0; i < 128; i++) wr(7'(i), 8'($urandom));
    wr(7'h05, 8'hC7);
    wr(7'h15, 8'h38);
    wr(7'h41, 8'h01);
    wr(7'h2A, 8'h02);
    wr(7'h00, 8'h9C);
    chk("reset_state", 11'h000);
    rst = 1'b0;

    pix3("bg_bank0", 4'd5, 1'b0, 6'h00, 1'b0, 4'h0, {2'b11, 8'hC7});
    pix3("bg_bank1", 4'd5, 1'b1, 6'h00, 1'b0, 4'h0, {2'b11, 8'h38});
    pix3("obj_over_bg", 4'd5, 1'b0, 6'h01, 1'b0, 4'h0, {2'b11, 8'h01});
    pix3("txt_over_obj", 4'd5, 1'b0, 6'h01, 1'b1, 4'hA, {2'b11, 8'h02});
    pix3("back_to_bg", 4'd5, 1'b0, 6'h00, 1'b0, 4'h0, {2'b11, 8'hC7});

    // Horizontal blank appears on the third edge, not earlier.
    bus.LHBL = 1'b0;
    repeat (2) @(negedge clk);
    chk("hblank_not_early", {2'b11, 8'hC7});
    @(negedge clk);
    chk("hblank_at_3", {2'b01, 8'h00});
    bus.LHBL = 1'b1;
    repeat (3) @(negedge clk);
    chk("hblank_release", {2'b11, 8'hC7});
    bus.LVBL = 1'b0;
    repeat (3) @(negedge clk);
    chk("vblank_at_3", {2'b10, 8'h00});
    bus.LVBL = 1'b1;
    repeat (3) @(negedge clk);

    // Write to the entry being read on the same clock.
    bus.prog_addr = 7'h05; bus.prog_data = 8'h5A; bus.prog_we = 1'b1;
    @(negedge clk);
    bus.prog_we = 1'b0;
    @(negedge clk);
    chk("collision_old", {2'b11, 8'hC7});
    @(negedge clk);
    chk("collision_new", {2'b11, 8'h5A});
    wr(7'h05, 8'hC7);

    // Sparse pxl_cen: 1 clock in 4.
    set_pix(4'd5, 1'b1, 6'h00, 1'b0, 4'h0);
    for (int i = 0; i < 12; i++) begin
      bus.pxl_cen = (i % 4 == 0);
      @(negedge clk);
    end
    chk("sparse_cen", {2'b11, 8'h38});

    // Asynchronous reset between edges.
    pix3("pre_reset", 4'd5, 1'b0, 6'h00, 1'b0, 4'h0, {2'b11, 8'hC7});
    #2 rst = 1'b1;
    #1 chk("async_reset", 11'h000);
    @(negedge clk);
    rst = 1'b0;
    pix3("palette_kept", 4'd5, 1'b0, 6'h00, 1'b0, 4'h0, {2'b11, 8'hC7});

`ifdef JTPOPEYE_LAYER_MASK_EN
    bus.gfx_en = 3'b101;
    pix3("mask_obj_off", 4'd5, 1'b0, 6'h01, 1'b0, 4'h0, {2'b11, 8'hC7});
    bus.gfx_en = 3'b000;
    pix3("mask_all_off", 4'd5, 1'b0, 6'h01, 1'b1, 4'hA, {2'b11, 8'h9C});
    bus.gfx_en = 3'b111;
`endif

    for (int i = 0; i < 4000; i++) begin
      logic [5:0] objc;
      bus.pxl_cen = ((i / 500) % 2 == 1) ? 1'b1 : ($urandom_range(3) == 0);
      objc = 6'($urandom);
      if ($urandom_range(1) == 0) objc[1:0] = 2'd0;
      set_pix(4'($urandom), 1'($urandom), objc, ($urandom_range(3) == 0), 4'($urandom));
      bus.LHBL = ($urandom_range(7) != 0);
      bus.LVBL = ($urandom_range(15) != 0);
      bus.prog_we = ($urandom_range(5) == 0);
      bus.prog_addr = ($urandom_range(1) == 0) ? {3'b000, bus.BAKC} : 7'($urandom);
      bus.prog_data = 8'($urandom);
`ifdef JTPOPEYE_LAYER_MASK_EN
      bus.gfx_en = ($urandom_range(3) == 0) ? 3'($urandom) : 3'b111;
`endif
      rst = ($urandom_range(499) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.prog_we = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
